// File: rtl/uart_echo_tester.sv
// Sends an N_BYTES pattern burst on tx, then checks the echoed burst arriving on rx.
// Latency: each rx mismatch is registered on its accept cycle; done pulses one cycle after the last byte or timeout.
// Backpressure: tx holds tx_data until tx_ready; rx is accepted only in RECV, bytes elsewhere are dropped.
module uart_echo_tester #(
    parameter int         N_BYTES        = 255,
    parameter logic [7:0] SEED           = 8'h01,
    parameter int         TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx
);
    localparam logic [7:0]  LAST_IDX   = 8'(N_BYTES - 1);
    // The idle counter starts at 0 on the accept edge, so the limit edge sees TIMEOUT_CYCLES-1.
    localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  idx;
    logic [31:0] idle_cnt;
    logic [7:0]  pattern;
    logic        tx_fire;
    logic        rx_fire;
    logic        last_idx;
    logic        rx_mismatch;
    logic        idle_expired;

    // Same pattern generator serves both the sender and the checker.
    assign pattern      = SEED + idx;
    assign tx_data      = pattern;
    assign tx_fire      = (state == SEND) && tx_ready;
    assign rx_fire      = (state == RECV) && rx_valid;
    assign last_idx     = (idx == LAST_IDX);
    assign rx_mismatch  = (rx_data != pattern);
    assign idle_expired = (idle_cnt == IDLE_LIMIT);

    // State register; reset aborts any running test without a done pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore handshake/status outputs.
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_fire && last_idx) begin
                    state_nxt = RECV;
                end
            end
            RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_fire && last_idx) begin
                    state_nxt = DONE;
                end else if (!rx_fire && idle_expired) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte index, idle counter and result registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx           <= 8'd0;
            idle_cnt      <= 32'd0;
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
            pass          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= 8'd0;
                        idle_cnt      <= 32'd0;
                        err_count     <= 8'd0;
                        first_err_idx <= 8'hFF;
                        pass          <= 1'b0;
                        timeout       <= 1'b0;
                    end
                end
                SEND: begin
                    // Idle counter is held at zero so RECV starts with a fresh window.
                    idle_cnt <= 32'd0;
                    if (tx_fire) begin
                        idx <= last_idx ? 8'd0 : idx + 8'd1;
                    end
                end
                RECV: begin
                    if (rx_fire) begin
                        idle_cnt <= 32'd0;
                        idx      <= idx + 8'd1;
                        if (rx_mismatch) begin
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                            if (first_err_idx == 8'hFF) begin
                                first_err_idx <= idx;
                            end
                        end
                    end else if (idle_expired) begin
                        timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                DONE: begin
                    pass <= (err_count == 8'd0) && !timeout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: pattern burst, echo loopback, corruption, stalls, timeout, resets, stray inputs.
// Latency: observes handshakes each cycle; results read one cycle after the done pulse.
// Backpressure: drives tx_ready patterns and gapped rx_valid to exercise both handshakes.
module tb_uart_echo_tester;
    localparam int         N    = 255;
    localparam logic [7:0] SEED = 8'h01;
    localparam int         TMO  = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] err_count;
    logic [7:0] first_err_idx;

    uart_echo_tester #(.N_BYTES(N), .SEED(SEED), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] err;
        logic [7:0] first;
        logic       pass;
        logic       tmo;
    } res_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];
    logic [7:0] echo[$];
    res_t       exp_res[$];
    int         seq_bad, stall_viol, rxrdy_viol;
    int         acc_cnt, last_acc, tmo_seen, done_cnt, done_cyc;

    // Pulse start and queue the expected transmit stream.
    task automatic do_start;
        exp_tx.delete();
        got_tx.delete();
        @(negedge clock);
        start = 1'b1;
        for (int i = 0; i < N; i++) exp_tx.push_back(SEED + 8'(i));
        @(negedge clock);
        start = 1'b0;
    endtask

    // Watch the SEND phase; every transfer pops the scoreboard.
    task automatic send_phase(input int ready_mod, input bit stray);
        logic [7:0] prev_dat = 8'h00;
        bit         prev_stall = 1'b0;
        logic [7:0] e;
        seq_bad = 0; stall_viol = 0; rxrdy_viol = 0;
        for (int c = 0; c < 4000; c++) begin
            tx_ready = (c % ready_mod == 0);
            if (stray) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                start    = (c == 20);
            end
            #1;
            if (!tx_valid) begin
                tx_ready = 1'b0; rx_valid = 1'b0; start = 1'b0;
                return;
            end
            if (rx_ready) rxrdy_viol++;
            if (prev_stall && tx_data !== prev_dat) stall_viol++;
            if (tx_ready) begin
                got_tx.push_back(tx_data);
                if (exp_tx.size() == 0) seq_bad++;
                else begin
                    e = exp_tx.pop_front();
                    if (tx_data !== e) seq_bad++;
                end
            end
            prev_stall = !tx_ready;
            prev_dat   = tx_data;
            @(negedge clock);
        end
        n_checks++; n_fail++;
        $display("FAIL send_bound: tx_valid still high after 4000 cycles, required low");
        tx_ready = 1'b0; rx_valid = 1'b0; start = 1'b0;
    endtask

    // Model of the checker's verdict for the current echo stream.
    task automatic set_expect(input int n_echo);
        res_t r;
        r.err = 8'd0; r.first = 8'hFF;
        for (int i = 0; i < n_echo; i++) begin
            if (echo[i] !== SEED + 8'(i)) begin
                if (r.err != 8'hFF) r.err = r.err + 8'd1;
                if (r.first == 8'hFF) r.first = 8'(i);
            end
        end
        r.tmo  = (n_echo < N);
        r.pass = (r.err == 8'd0) && !r.tmo;
        exp_res.push_back(r);
    endtask

    // Feed echo bytes (with periodic gaps); stop one cycle after done, or once reset_after bytes are in.
    task automatic recv_phase(input int n_echo, input int reset_after);
        acc_cnt = 0; last_acc = -1; tmo_seen = -1; done_cnt = 0; done_cyc = -1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            if (reset_after > 0 && acc_cnt == reset_after) begin
                rx_valid = 1'b0;
                return;
            end
            rx_valid = (acc_cnt < n_echo) && (c % 7 != 3);
            rx_data  = (acc_cnt < echo.size()) ? echo[acc_cnt] : 8'h00;
            #1;
            if (timeout === 1'b1 && tmo_seen < 0) tmo_seen = c;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                rx_valid = 1'b0;
                return;
            end
            if (rx_valid && rx_ready) begin
                acc_cnt++;
                last_acc = c;
            end
        end
        n_checks++; n_fail++;
        $display("FAIL recv_bound: no done within 1500 cycles, accepted %0d", acc_cnt);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        int viol = 0;
        reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A;
        repeat (2) @(negedge clock);
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL rst_pass: got %b want 0", pass); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err_count: got %h want 00", err_count); end
        n_checks++; if (first_err_idx !== 8'hFF) begin n_fail++; $display("FAIL rst_first_err: got %h want FF", first_err_idx); end
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock); #1;
            if (rx_ready !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) viol++;
        end
        rx_valid = 1'b0;
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL idle_stray: %0d cycles left IDLE without start, want 0", viol); end
    endtask

    task automatic test_loopback;
        res_t r;
        do_start;
        send_phase(1, 1'b0);
        n_checks++; if (got_tx.size() !== N) begin n_fail++; $display("FAIL loop_tx_count: got %0d want %0d", got_tx.size(), N); end
        n_checks++; if (seq_bad !== 0) begin n_fail++; $display("FAIL loop_tx_order: %0d bad bytes want 0", seq_bad); end
        echo = got_tx;
        set_expect(N);
        recv_phase(N, 0);
        r = exp_res.pop_front();
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL loop_done: %0d done cycles want 1", done_cnt); end
        n_checks++; if (pass !== r.pass) begin n_fail++; $display("FAIL loop_pass: got %b want %b", pass, r.pass); end
        n_checks++; if (err_count !== r.err) begin n_fail++; $display("FAIL loop_err: got %h want %h", err_count, r.err); end
        n_checks++; if (first_err_idx !== r.first) begin n_fail++; $display("FAIL loop_first: got %h want %h", first_err_idx, r.first); end
    endtask

    task automatic test_corrupt;
        res_t r;
        do_start;
        send_phase(1, 1'b0);
        echo = got_tx;
        echo[10]  = 8'h00;
        echo[200] = echo[200] ^ 8'h80;
        set_expect(N);
        recv_phase(N, 0);
        r = exp_res.pop_front();
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL corr_done: %0d done cycles want 1", done_cnt); end
        n_checks++; if (err_count !== r.err) begin n_fail++; $display("FAIL corr_err: got %h want %h", err_count, r.err); end
        n_checks++; if (first_err_idx !== r.first) begin n_fail++; $display("FAIL corr_first: got %h want %h", first_err_idx, r.first); end
        n_checks++; if (pass !== r.pass) begin n_fail++; $display("FAIL corr_pass: got %b want %b", pass, r.pass); end
    endtask

    task automatic test_backpressure;
        res_t r;
        do_start;
        send_phase(4, 1'b0);
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stable: %0d stall changes want 0", stall_viol); end
        n_checks++; if (got_tx.size() !== N) begin n_fail++; $display("FAIL bp_tx_count: got %0d want %0d", got_tx.size(), N); end
        n_checks++; if (seq_bad !== 0) begin n_fail++; $display("FAIL bp_tx_order: %0d bad bytes want 0", seq_bad); end
        echo = got_tx;
        set_expect(N);
        recv_phase(N, 0);
        r = exp_res.pop_front();
        n_checks++; if (pass !== r.pass) begin n_fail++; $display("FAIL bp_pass: got %b want %b", pass, r.pass); end
    endtask

    task automatic test_truncated;
        res_t r;
        do_start;
        send_phase(1, 1'b0);
        echo = got_tx;
        set_expect(N - 1);
        recv_phase(N - 1, 0);
        r = exp_res.pop_front();
        n_checks++; if (timeout !== r.tmo) begin n_fail++; $display("FAIL trunc_timeout: got %b want %b", timeout, r.tmo); end
        // Timeout register rises on the edge TMO clocks after the last accept edge, seen at the following sample.
        n_checks++; if (tmo_seen !== last_acc + TMO + 1) begin n_fail++; $display("FAIL trunc_timing: timeout seen at %0d want %0d", tmo_seen, last_acc + TMO + 1); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL trunc_done: %0d done cycles want 1", done_cnt); end
        n_checks++; if (pass !== r.pass) begin n_fail++; $display("FAIL trunc_pass: got %b want %b", pass, r.pass); end
        n_checks++; if (acc_cnt !== N - 1) begin n_fail++; $display("FAIL trunc_accepted: got %0d want %0d", acc_cnt, N - 1); end
    endtask

    task automatic test_reset_mid_send;
        do_start;
        tx_ready = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL msend_pre: tx_valid got %b want 1", tx_valid); end
        reset = 1'b0;
        @(negedge clock); #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL msend_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL msend_status: busy %b done %b want 0 0", busy, done); end
        reset = 1'b1; tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_recv;
        res_t r;
        int   dones = 0;
        do_start;
        send_phase(1, 1'b0);
        echo = got_tx;
        echo[5] = echo[5] ^ 8'h01;
        recv_phase(N, 50);
        #1;
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL mrecv_pre_err: got %h want 01", err_count); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if (err_count !== 8'd0 || first_err_idx !== 8'hFF) begin n_fail++; $display("FAIL mrecv_clear: err %h first %h want 00 FF", err_count, first_err_idx); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clock); #1;
            if (done === 1'b1 || busy !== 1'b0) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mrecv_no_done: %0d done/busy cycles want 0", dones); end
        do_start;
        send_phase(1, 1'b0);
        echo = got_tx;
        set_expect(N);
        recv_phase(N, 0);
        r = exp_res.pop_front();
        n_checks++; if (pass !== r.pass || err_count !== r.err) begin n_fail++; $display("FAIL mrecv_rerun: pass %b err %h want %b %h", pass, err_count, r.pass, r.err); end
    endtask

    task automatic test_stray;
        res_t r;
        do_start;
        send_phase(1, 1'b1);
        n_checks++; if (got_tx.size() !== N) begin n_fail++; $display("FAIL stray_tx_count: got %0d want %0d", got_tx.size(), N); end
        n_checks++; if (seq_bad !== 0) begin n_fail++; $display("FAIL stray_tx_order: %0d bad bytes want 0", seq_bad); end
        n_checks++; if (rxrdy_viol !== 0) begin n_fail++; $display("FAIL stray_rx_ready: %0d cycles high in SEND want 0", rxrdy_viol); end
        echo = got_tx;
        set_expect(N);
        recv_phase(N, 0);
        r = exp_res.pop_front();
        n_checks++; if (err_count !== r.err) begin n_fail++; $display("FAIL stray_err: got %h want %h", err_count, r.err); end
        n_checks++; if (pass !== r.pass) begin n_fail++; $display("FAIL stray_pass: got %b want %b", pass, r.pass); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset;
        test_loopback;
        test_corrupt;
        test_backpressure;
        test_truncated;
        test_reset_mid_send;
        test_reset_mid_recv;
        test_stray;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
